// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Bundle between the D-stage Tuse/Tnew decoder (master side) and
//            the hazard controller (slave side).
// Signals  : tuse_rs/tuse_rt/res_d/rs_d/rt_d/dst_d/flush  master -> slave
//            stall/fwd_rs_d/fwd_rt_d/fwd_rs_e/fwd_rt_e/fwd_rt_m/stall_cnt
//                                                         slave  -> master
// Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 32
);
    logic [1:0]      tuse_rs;
    logic [1:0]      tuse_rt;
    logic [2:0]      res_d;
    logic [REGW-1:0] rs_d;
    logic [REGW-1:0] rt_d;
    logic [REGW-1:0] dst_d;
    logic            flush;
    logic            stall;
    logic [1:0]      fwd_rs_d;
    logic [1:0]      fwd_rt_d;
    logic [1:0]      fwd_rs_e;
    logic [1:0]      fwd_rt_e;
    logic            fwd_rt_m;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output tuse_rs, tuse_rt, res_d, rs_d, rt_d, dst_d, flush,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_cnt
    );

    modport slave (
        input  tuse_rs, tuse_rt, res_d, rs_d, rt_d, dst_d, flush,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/forward controller for the 5-stage MIPS core. Keeps a
//            shadow copy of destination, result class and remaining Tnew for
//            the E/M/W stages and compares them with the D-stage Tuse to
//            produce the stall and every bypass-mux select.
// Ports    : clk    - core clock (rising edge)
//            reset  - synchronous, active-high; empties the shadow pipeline
//            hz     - hazard_ctrl_if.slave (decoder inputs, stall, fwd_*,
//                     stall_cnt)
// Options  : HAZARD_STATS_EN - when defined, stall_cnt counts stall cycles
//                              (saturating); otherwise stall_cnt is tied 0.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [2:0] c_RES_NW  = 3'd0;
    localparam logic [2:0] c_RES_ALU = 3'd1;
    localparam logic [2:0] c_RES_DM  = 3'd2;

    localparam logic [REGW-1:0] c_REG_ZERO = '0;

    // ---------------- shadow pipeline ----------------
    logic [REGW-1:0] r_e_dst, r_e_rs, r_e_rt;
    logic [2:0]      r_e_res;
    logic [1:0]      r_e_tnew;

    logic [REGW-1:0] r_m_dst, r_m_rt;
    logic [2:0]      r_m_res;
    logic [1:0]      r_m_tnew;

    // W tnew is always zero, so only the write target is kept.
    logic [REGW-1:0] r_w_dst;
    logic [2:0]      r_w_res;

    logic            w_e_wr, w_m_wr, w_w_wr;
    logic [1:0]      w_tnew_d;
    logic            w_stall;

    // Hit flags: D operands against E/M/W, E operands against M/W.
    logic w_rs_e_hit, w_rs_m_hit, w_rs_w_hit;
    logic w_rt_e_hit, w_rt_m_hit, w_rt_w_hit;
    logic w_ers_m_hit, w_ers_w_hit, w_ert_m_hit, w_ert_w_hit;
    logic w_mrt_w_hit;

    logic [1:0] w_fwd_rs_d, w_fwd_rt_d, w_fwd_rs_e, w_fwd_rt_e;

    assign w_e_wr = (r_e_res != c_RES_NW) && (r_e_dst != c_REG_ZERO);
    assign w_m_wr = (r_m_res != c_RES_NW) && (r_m_dst != c_REG_ZERO);
    assign w_w_wr = (r_w_res != c_RES_NW) && (r_w_dst != c_REG_ZERO);

    // Cycles until the D instruction's result exists once it reaches E.
    always_comb begin
        w_tnew_d = 2'd0;
        if (hz.res_d == c_RES_DM) begin
            w_tnew_d = 2'd2;
        end else if (hz.res_d == c_RES_ALU) begin
            w_tnew_d = 2'd1;
        end
    end

    assign w_rs_e_hit = w_e_wr && (hz.rs_d != c_REG_ZERO) && (hz.rs_d == r_e_dst);
    assign w_rs_m_hit = w_m_wr && (hz.rs_d != c_REG_ZERO) && (hz.rs_d == r_m_dst);
    assign w_rs_w_hit = w_w_wr && (hz.rs_d != c_REG_ZERO) && (hz.rs_d == r_w_dst);
    assign w_rt_e_hit = w_e_wr && (hz.rt_d != c_REG_ZERO) && (hz.rt_d == r_e_dst);
    assign w_rt_m_hit = w_m_wr && (hz.rt_d != c_REG_ZERO) && (hz.rt_d == r_m_dst);
    assign w_rt_w_hit = w_w_wr && (hz.rt_d != c_REG_ZERO) && (hz.rt_d == r_w_dst);

    assign w_ers_m_hit = w_m_wr && (r_e_rs != c_REG_ZERO) && (r_e_rs == r_m_dst);
    assign w_ers_w_hit = w_w_wr && (r_e_rs != c_REG_ZERO) && (r_e_rs == r_w_dst);
    assign w_ert_m_hit = w_m_wr && (r_e_rt != c_REG_ZERO) && (r_e_rt == r_m_dst);
    assign w_ert_w_hit = w_w_wr && (r_e_rt != c_REG_ZERO) && (r_e_rt == r_w_dst);
    assign w_mrt_w_hit = w_w_wr && (r_m_rt != c_REG_ZERO) && (r_m_rt == r_w_dst);

    // Tuse of 3 (operand unused) can never be below a Tnew of at most 2.
    assign w_stall = (w_rs_e_hit && (hz.tuse_rs < r_e_tnew)) ||
                     (w_rs_m_hit && (hz.tuse_rs < r_m_tnew)) ||
                     (w_rt_e_hit && (hz.tuse_rt < r_e_tnew)) ||
                     (w_rt_m_hit && (hz.tuse_rt < r_m_tnew));

    // The nearest producer decides: if it is not ready yet, older copies
    // further down the pipe are stale, so nothing is forwarded.
    always_comb begin
        w_fwd_rs_d = 2'd0;
        if (w_rs_e_hit) begin
            w_fwd_rs_d = (r_e_tnew == 2'd0) ? 2'd1 : 2'd0;
        end else if (w_rs_m_hit) begin
            w_fwd_rs_d = (r_m_tnew == 2'd0) ? 2'd2 : 2'd0;
        end else if (w_rs_w_hit) begin
            w_fwd_rs_d = 2'd3;
        end
    end

    always_comb begin
        w_fwd_rt_d = 2'd0;
        if (w_rt_e_hit) begin
            w_fwd_rt_d = (r_e_tnew == 2'd0) ? 2'd1 : 2'd0;
        end else if (w_rt_m_hit) begin
            w_fwd_rt_d = (r_m_tnew == 2'd0) ? 2'd2 : 2'd0;
        end else if (w_rt_w_hit) begin
            w_fwd_rt_d = 2'd3;
        end
    end

    always_comb begin
        w_fwd_rs_e = 2'd0;
        if (w_ers_m_hit) begin
            w_fwd_rs_e = (r_m_tnew == 2'd0) ? 2'd1 : 2'd0;
        end else if (w_ers_w_hit) begin
            w_fwd_rs_e = 2'd2;
        end
    end

    always_comb begin
        w_fwd_rt_e = 2'd0;
        if (w_ert_m_hit) begin
            w_fwd_rt_e = (r_m_tnew == 2'd0) ? 2'd1 : 2'd0;
        end else if (w_ert_w_hit) begin
            w_fwd_rt_e = 2'd2;
        end
    end

    // ---------------- shadow pipeline advance ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_dst  <= '0;
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_e_res  <= c_RES_NW;
            r_e_tnew <= 2'd0;
            r_m_dst  <= '0;
            r_m_rt   <= '0;
            r_m_res  <= c_RES_NW;
            r_m_tnew <= 2'd0;
            r_w_dst  <= '0;
            r_w_res  <= c_RES_NW;
        end else begin
            // W always takes the old M, even across a flush.
            r_w_dst <= r_m_dst;
            r_w_res <= r_m_res;
            if (hz.flush) begin
                r_e_dst  <= '0;
                r_e_rs   <= '0;
                r_e_rt   <= '0;
                r_e_res  <= c_RES_NW;
                r_e_tnew <= 2'd0;
                r_m_dst  <= '0;
                r_m_rt   <= '0;
                r_m_res  <= c_RES_NW;
                r_m_tnew <= 2'd0;
            end else begin
                r_m_dst  <= r_e_dst;
                r_m_rt   <= r_e_rt;
                r_m_res  <= r_e_res;
                r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : (r_e_tnew - 2'd1);
                if (w_stall) begin
                    r_e_dst  <= '0;
                    r_e_rs   <= '0;
                    r_e_rt   <= '0;
                    r_e_res  <= c_RES_NW;
                    r_e_tnew <= 2'd0;
                end else begin
                    r_e_dst  <= hz.dst_d;
                    r_e_rs   <= hz.rs_d;
                    r_e_rt   <= hz.rt_d;
                    r_e_res  <= hz.res_d;
                    r_e_tnew <= w_tnew_d;
                end
            end
        end
    end

    assign hz.stall    = w_stall;
    assign hz.fwd_rs_d = w_fwd_rs_d;
    assign hz.fwd_rt_d = w_fwd_rt_d;
    assign hz.fwd_rs_e = w_fwd_rs_e;
    assign hz.fwd_rt_e = w_fwd_rt_e;
    assign hz.fwd_rt_m = w_mrt_w_hit;

`ifdef HAZARD_STATS_EN
    logic [CNTW-1:0] r_stall_cnt;

    // Saturating; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNTW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
`else
    assign hz.stall_cnt = {CNTW{1'b0}};
`endif

endmodule
`default_nettype wire
